// File: rtl/normalize_block_pkg.sv
// ---------------------------------------------------------------------------
// normalize_block_pkg
// Shared softmax definitions used by the adder and normalize stages.
//   norm_state_t : state encoding of the normalize controller
//   SUM_SHIFT    : right shift the adder stage applies to its running sum
//                  (sum_i == true_sum >> SUM_SHIFT)
// ---------------------------------------------------------------------------
package normalize_block_pkg;

   localparam int SUM_SHIFT = 4;

   typedef enum logic [2:0] {
      ST_COLLECT  = 3'd0,
      ST_WAIT_SUM = 3'd1,
      ST_LOAD     = 3'd2,
      ST_DIVIDE   = 3'd3,
      ST_OUTPUT   = 3'd4,
      ST_DONE     = 3'd5
   } norm_state_t;

endpackage

// File: rtl/normalize_block_divider.sv
// ---------------------------------------------------------------------------
// serial_divider
// Restoring divider, one quotient bit per clock, MSB first, data_size steps.
// Ports:
//   clock_i, reset_i : clock, synchronous active-high reset
//   start            : load dividend/divisor and begin a new division
//   dividend         : 2*data_size-SUM_SHIFT bit unsigned dividend
//   divisor          : data_size bit unsigned divisor
//   quotient         : low data_size bits of floor(dividend/divisor)
//   done             : high during the cycle whose edge completes the last step
//   saturate         : result does not fit in data_size bits (or divisor is 0)
// ---------------------------------------------------------------------------
module serial_divider
   import normalize_block_pkg::*;
#(
   parameter int data_size = 32
) (
   input  logic                                 clock_i,
   input  logic                                 reset_i,
   input  logic                                 start,
   input  logic [2*data_size-SUM_SHIFT-1:0]     dividend,
   input  logic [data_size-1:0]                 divisor,
   output logic [data_size-1:0]                 quotient,
   output logic                                 done,
   output logic                                 saturate
);

   localparam int DVW = 2*data_size - SUM_SHIFT;
   localparam int CW  = $clog2(data_size + 1);

   logic [data_size-1:0] remainder;
   logic [data_size-1:0] low_bits;
   logic [CW-1:0]        steps_left;
   logic [data_size:0]   trial;
   logic [data_size-1:0] high_part;

   // The dividend bits above data_size form the starting partial remainder.
   // If that alone is >= divisor, the quotient needs more than data_size bits,
   // so the result saturates and only the low data_size quotient bits are
   // ever iterated.
   always_comb begin
      high_part = data_size'(dividend[DVW-1:data_size]);
      trial     = {remainder, low_bits[data_size-1]};
   end

   // One restoring step per clock while steps remain.
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         remainder  <= '0;
         low_bits   <= '0;
         quotient   <= '0;
         steps_left <= '0;
         saturate   <= 1'b0;
      end else if (start) begin
         remainder  <= high_part;
         low_bits   <= dividend[data_size-1:0];
         quotient   <= '0;
         steps_left <= CW'(data_size);
         saturate   <= (divisor == '0) || (high_part >= divisor);
      end else if (steps_left != '0) begin
         if (trial >= {1'b0, divisor}) begin
            remainder <= data_size'(trial - {1'b0, divisor});
            quotient  <= {quotient[data_size-2:0], 1'b1};
         end else begin
            remainder <= trial[data_size-1:0];
            quotient  <= {quotient[data_size-2:0], 1'b0};
         end
         low_bits   <= low_bits << 1;
         steps_left <= steps_left - CW'(1);
      end
   end

   assign done = (steps_left == CW'(1));

endmodule

// File: rtl/normalize_block.sv
// ---------------------------------------------------------------------------
// normalize_block
// Buffers exp values, waits for the accumulated sum, then emits one
// probability word per element: prob = (exp << (data_size-4)) / sum,
// saturated to all-ones.
// Ports:
//   clock_i, reset_i        : clock, synchronous active-high reset
//   exp_i, data_valid_i     : exp values from the exp stage
//   exp_done_i              : exp stream finished (level)
//   sum_i, sum_valid_i      : scaled sum from the adder stage (level)
//   prob_o, prob_valid_o    : probability word and its one-cycle strobe
//   prob_last_o             : marks the final element of the vector
//   busy_o, done_o          : controller status
//   overflow_o              : sticky, an exp was dropped because buffer full
// ---------------------------------------------------------------------------
module normalize_block
   import normalize_block_pkg::*;
#(
   parameter int data_size      = 32,
   parameter int number_of_data = 10
) (
   input  logic                 clock_i,
   input  logic                 reset_i,
   input  logic [data_size-1:0] exp_i,
   input  logic                 data_valid_i,
   input  logic                 exp_done_i,
   input  logic [data_size-1:0] sum_i,
   input  logic                 sum_valid_i,
   output logic [data_size-1:0] prob_o,
   output logic                 prob_valid_o,
   output logic                 prob_last_o,
   output logic                 busy_o,
   output logic                 done_o,
   output logic                 overflow_o
);

   localparam int DVW = 2*data_size - SUM_SHIFT;
   localparam int CW  = $clog2(number_of_data + 1);
   localparam int IW  = (number_of_data > 1) ? $clog2(number_of_data) : 1;

   norm_state_t          state, next_state;
   logic [data_size-1:0] buffer [number_of_data];
   logic [CW-1:0]        count;
   logic [CW-1:0]        idx;
   logic [data_size-1:0] divisor;
   logic [DVW-1:0]       dividend;
   logic                 capture;
   logic                 buffer_full;
   logic                 is_last;
   logic                 div_start;
   logic                 div_done;
   logic                 div_saturate;
   logic [data_size-1:0] div_quotient;

   // Words arriving together with exp_done are deliberately not captured.
   always_comb begin
      capture     = (state == ST_COLLECT) && data_valid_i && !exp_done_i;
      buffer_full = (count == CW'(number_of_data));
      is_last     = (idx == count - CW'(1));
      dividend    = DVW'(buffer[idx[IW-1:0]]) << (data_size - SUM_SHIFT);
   end

   // State register.
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         state <= ST_COLLECT;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic; an empty vector goes straight to DONE.
   always_comb begin
      next_state = state;
      case (state)
         ST_COLLECT: begin
            if (exp_done_i) begin
               next_state = (count == '0) ? ST_DONE : ST_WAIT_SUM;
            end
         end
         ST_WAIT_SUM: begin
            if (sum_valid_i) begin
               next_state = ST_LOAD;
            end
         end
         ST_LOAD: begin
            next_state = ST_DIVIDE;
         end
         ST_DIVIDE: begin
            if (div_done) begin
               next_state = ST_OUTPUT;
            end
         end
         ST_OUTPUT: begin
            next_state = is_last ? ST_DONE : ST_LOAD;
         end
         ST_DONE: begin
            next_state = ST_DONE;
         end
         default: begin
            next_state = ST_COLLECT;
         end
      endcase
   end

   // Moore outputs decoded from the state.
   always_comb begin
      busy_o    = 1'b0;
      done_o    = 1'b0;
      div_start = 1'b0;
      case (state)
         ST_LOAD: begin
            busy_o    = 1'b1;
            div_start = 1'b1;
         end
         ST_DIVIDE: begin
            busy_o = 1'b1;
         end
         ST_OUTPUT: begin
            busy_o = 1'b1;
         end
         ST_DONE: begin
            done_o = 1'b1;
         end
         default: begin
            busy_o = 1'b0;
         end
      endcase
   end

   // Element counters, divisor capture and the sticky overflow flag.
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         count      <= '0;
         idx        <= '0;
         divisor    <= '0;
         overflow_o <= 1'b0;
      end else begin
         if (capture) begin
            if (buffer_full) begin
               overflow_o <= 1'b1;
            end else begin
               count <= count + CW'(1);
            end
         end
         if ((state == ST_WAIT_SUM) && sum_valid_i) begin
            divisor <= sum_i;
            idx     <= '0;
         end
         if ((state == ST_OUTPUT) && !is_last) begin
            idx <= idx + CW'(1);
         end
      end
   end

   // Exp storage is not reset; count alone says which entries are live.
   always_ff @(posedge clock_i) begin
      if (capture && !buffer_full) begin
         buffer[count[IW-1:0]] <= exp_i;
      end
   end

   // Result register: strobe is a single cycle, prob_o holds between strobes.
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         prob_o       <= '0;
         prob_valid_o <= 1'b0;
         prob_last_o  <= 1'b0;
      end else begin
         prob_valid_o <= 1'b0;
         prob_last_o  <= 1'b0;
         if (state == ST_OUTPUT) begin
            prob_valid_o <= 1'b1;
            prob_last_o  <= is_last;
            prob_o       <= div_saturate ? '1 : div_quotient;
         end
      end
   end

   serial_divider #(
      .data_size (data_size)
   ) u_divider (
      .clock_i  (clock_i),
      .reset_i  (reset_i),
      .start    (div_start),
      .dividend (dividend),
      .divisor  (divisor),
      .quotient (div_quotient),
      .done     (div_done),
      .saturate (div_saturate)
   );

endmodule

// File: tb/tb_normalize_block.sv
// ---------------------------------------------------------------------------
// tb_normalize_block
// Directed bench for normalize_block with data_size=32, number_of_data=4.
// Expected probabilities are hand-computed as (exp << 28) / sum, saturated.
// ---------------------------------------------------------------------------
module tb_normalize_block;

   localparam int DS = 32;
   localparam int ND = 4;
   localparam int ELEM_CYCLES = DS + 2;

   logic          clock_i;
   logic          reset_i;
   logic [DS-1:0] exp_i;
   logic          data_valid_i;
   logic          exp_done_i;
   logic [DS-1:0] sum_i;
   logic          sum_valid_i;
   logic [DS-1:0] prob_o;
   logic          prob_valid_o;
   logic          prob_last_o;
   logic          busy_o;
   logic          done_o;
   logic          overflow_o;

   int checks = 0;
   int errors = 0;

   normalize_block #(
      .data_size      (DS),
      .number_of_data (ND)
   ) dut (
      .clock_i      (clock_i),
      .reset_i      (reset_i),
      .exp_i        (exp_i),
      .data_valid_i (data_valid_i),
      .exp_done_i   (exp_done_i),
      .sum_i        (sum_i),
      .sum_valid_i  (sum_valid_i),
      .prob_o       (prob_o),
      .prob_valid_o (prob_valid_o),
      .prob_last_o  (prob_last_o),
      .busy_o       (busy_o),
      .done_o       (done_o),
      .overflow_o   (overflow_o)
   );

   initial clock_i = 1'b0;
   always #5 clock_i = ~clock_i;

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
      end
   endtask

   // Advance one edge and settle just after it.
   task automatic tick();
      @(posedge clock_i);
      #1;
   endtask

   task automatic applyStimulus(input logic [DS-1:0] value);
      exp_i        = value;
      data_valid_i = 1'b1;
      tick();
      data_valid_i = 1'b0;
      exp_i        = '0;
   endtask

   task automatic endStream();
      exp_done_i = 1'b1;
      tick();
   endtask

   task automatic giveSum(input logic [DS-1:0] value);
      sum_i       = value;
      sum_valid_i = 1'b1;
      tick();
   endtask

   task automatic resetDut();
      reset_i      = 1'b1;
      exp_i        = '0;
      data_valid_i = 1'b0;
      exp_done_i   = 1'b0;
      sum_i        = '0;
      sum_valid_i  = 1'b0;
      tick();
      tick();
      reset_i = 1'b0;
   endtask

   // Wait (bounded) for the next strobe and check its gap, value and last flag.
   task automatic expectElement(input string tag, input int gap,
                                input logic [DS-1:0] prob, input logic last);
      int waited;
      waited = 0;
      do begin
         tick();
         waited++;
      end while (!prob_valid_o && waited < 200);
      checkOutput({tag, "_gap"}, 32'(waited), 32'(gap));
      checkOutput({tag, "_valid"}, {31'd0, prob_valid_o}, 32'd1);
      checkOutput({tag, "_prob"}, prob_o, prob);
      checkOutput({tag, "_last"}, {31'd0, prob_last_o}, {31'd0, last});
   endtask

   task automatic countStrobes(input int cycles, output int strobes);
      strobes = 0;
      for (int i = 0; i < cycles; i++) begin
         tick();
         if (prob_valid_o) strobes++;
      end
   endtask

   initial begin
      int strobes;

      // ---- reset state ----
      resetDut();
      checkOutput("rst_prob",     prob_o, 32'h0);
      checkOutput("rst_valid",    {31'd0, prob_valid_o}, 32'd0);
      checkOutput("rst_last",     {31'd0, prob_last_o}, 32'd0);
      checkOutput("rst_busy",     {31'd0, busy_o}, 32'd0);
      checkOutput("rst_done",     {31'd0, done_o}, 32'd0);
      checkOutput("rst_overflow", {31'd0, overflow_o}, 32'd0);

      // ---- four equal exps: 2^28 * 2^28 / 2^26 = 2^30 ----
      for (int i = 0; i < 4; i++) applyStimulus(32'h1000_0000);
      endStream();
      checkOutput("eq_waitsum_busy", {31'd0, busy_o}, 32'd0);
      giveSum(32'h0400_0000);
      checkOutput("eq_load_busy", {31'd0, busy_o}, 32'd1);
      expectElement("eq_e0", ELEM_CYCLES, 32'h4000_0000, 1'b0);
      tick();
      checkOutput("eq_hold_prob",  prob_o, 32'h4000_0000);
      checkOutput("eq_hold_valid", {31'd0, prob_valid_o}, 32'd0);
      expectElement("eq_e1", ELEM_CYCLES - 1, 32'h4000_0000, 1'b0);
      expectElement("eq_e2", ELEM_CYCLES, 32'h4000_0000, 1'b0);
      expectElement("eq_e3", ELEM_CYCLES, 32'h4000_0000, 1'b1);
      checkOutput("eq_done", {31'd0, done_o}, 32'd1);
      checkOutput("eq_busy_end", {31'd0, busy_o}, 32'd0);
      // DONE ignores further traffic
      applyStimulus(32'h0000_0055);
      countStrobes(40, strobes);
      checkOutput("eq_done_quiet", 32'(strobes), 32'd0);
      checkOutput("eq_done_hold", {31'd0, done_o}, 32'd1);

      // ---- single exp, quotient exactly 2^32 saturates ----
      resetDut();
      applyStimulus(32'h0800_0000);
      endStream();
      giveSum(32'h0080_0000);
      expectElement("sat1", ELEM_CYCLES, 32'hFFFF_FFFF, 1'b1);
      checkOutput("sat1_done", {31'd0, done_o}, 32'd1);

      // ---- zero then saturated element ----
      resetDut();
      applyStimulus(32'h0000_0000);
      applyStimulus(32'h0200_0000);
      endStream();
      giveSum(32'h0020_0000);
      expectElement("zs_e0", ELEM_CYCLES, 32'h0000_0000, 1'b0);
      expectElement("zs_e1", ELEM_CYCLES, 32'hFFFF_FFFF, 1'b1);

      // ---- zero divisor: all-ones, normal timing ----
      resetDut();
      applyStimulus(32'h0000_0001);
      applyStimulus(32'h0000_1234);
      applyStimulus(32'h0000_0000);
      endStream();
      giveSum(32'h0000_0000);
      expectElement("dz_e0", ELEM_CYCLES, 32'hFFFF_FFFF, 1'b0);
      expectElement("dz_e1", ELEM_CYCLES, 32'hFFFF_FFFF, 1'b0);
      expectElement("dz_e2", ELEM_CYCLES, 32'hFFFF_FFFF, 1'b1);

      // ---- six exps into depth four: e * 16 for the first four ----
      resetDut();
      applyStimulus(32'h0100_0000);
      applyStimulus(32'h0200_0000);
      applyStimulus(32'h0300_0000);
      applyStimulus(32'h0400_0000);
      checkOutput("of_full_no_flag", {31'd0, overflow_o}, 32'd0);
      applyStimulus(32'h0500_0000);
      checkOutput("of_flag", {31'd0, overflow_o}, 32'd1);
      applyStimulus(32'h0600_0000);
      endStream();
      giveSum(32'h0100_0000);
      expectElement("of_e0", ELEM_CYCLES, 32'h1000_0000, 1'b0);
      expectElement("of_e1", ELEM_CYCLES, 32'h2000_0000, 1'b0);
      expectElement("of_e2", ELEM_CYCLES, 32'h3000_0000, 1'b0);
      expectElement("of_e3", ELEM_CYCLES, 32'h4000_0000, 1'b1);
      countStrobes(40, strobes);
      checkOutput("of_no_extra", 32'(strobes), 32'd0);
      checkOutput("of_sticky", {31'd0, overflow_o}, 32'd1);

      // ---- empty vector; data coincident with exp_done is dropped ----
      resetDut();
      exp_i        = 32'h0000_1234;
      data_valid_i = 1'b1;
      endStream();
      data_valid_i = 1'b0;
      checkOutput("empty_done", {31'd0, done_o}, 32'd1);
      checkOutput("empty_busy", {31'd0, busy_o}, 32'd0);
      sum_i       = 32'h0000_0010;
      sum_valid_i = 1'b1;
      countStrobes(40, strobes);
      checkOutput("empty_no_strobe", 32'(strobes), 32'd0);

      // ---- reset during DIVIDE of element 2, then a fresh vector ----
      resetDut();
      for (int i = 0; i < 3; i++) applyStimulus(32'h1000_0000);
      endStream();
      giveSum(32'h0400_0000);
      expectElement("ab_e0", ELEM_CYCLES, 32'h4000_0000, 1'b0);
      for (int i = 0; i < 10; i++) tick();
      reset_i      = 1'b1;
      exp_done_i   = 1'b0;
      sum_valid_i  = 1'b0;
      tick();
      reset_i = 1'b0;
      checkOutput("ab_prob",  prob_o, 32'h0);
      checkOutput("ab_valid", {31'd0, prob_valid_o}, 32'd0);
      checkOutput("ab_busy",  {31'd0, busy_o}, 32'd0);
      checkOutput("ab_done",  {31'd0, done_o}, 32'd0);
      countStrobes(40, strobes);
      checkOutput("ab_quiet", 32'(strobes), 32'd0);
      applyStimulus(32'h0200_0000);
      applyStimulus(32'h0600_0000);
      endStream();
      giveSum(32'h0800_0000);
      expectElement("ab_n0", ELEM_CYCLES, 32'h0400_0000, 1'b0);
      expectElement("ab_n1", ELEM_CYCLES, 32'h0C00_0000, 1'b1);
      checkOutput("ab_n_done", {31'd0, done_o}, 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/normalize_block.md
NORMALIZE_BLOCK -- requirements
Module: normalize_block

Interface
REQ-001 Parameter data_size, default 32: width of exp, sum and probability words.
REQ-002 Parameter number_of_data, default 10: exp buffer depth (max elements per vector).
REQ-003 clock_i  input  1  sole clock; all logic on its rising edge.
REQ-004 reset_i  input  1  reset, synchronous, active-high.
REQ-005 exp_i  input  data_size  unsigned exp value from exp stage.
REQ-006 data_valid_i  input  1  exp_i valid this cycle.
REQ-007 exp_done_i  input  1  exp stream finished (level, held high until reset).
REQ-008 sum_i  input  data_size  accumulated sum from adder stage, equal to true sum >> 4.
REQ-009 sum_valid_i  input  1  sum_i valid (level, held high until reset).
REQ-010 prob_o  output  data_size  probability, unsigned fraction, value = prob_o / 2^data_size.
REQ-011 prob_valid_o  output  1  one-cycle strobe per prob_o word.
REQ-012 prob_last_o  output  1  high with prob_valid_o on final element.
REQ-013 busy_o  output  1  high in LOAD/DIVIDE/OUTPUT.
REQ-014 done_o  output  1  high in DONE.
REQ-015 overflow_o  output  1  sticky: exp dropped because buffer full.

Function
REQ-016 Capture: when data_valid_i=1 and exp_done_i=0 in COLLECT, exp_i written to buffer[count], count+1; if count=number_of_data, word dropped, overflow_o set.
REQ-017 data_valid_i coincident with exp_done_i: word not captured.
REQ-018 States: COLLECT, WAIT_SUM, LOAD, DIVIDE, OUTPUT, DONE.
REQ-019 COLLECT -> WAIT_SUM when exp_done_i=1; if count=0 at that edge, COLLECT -> DONE.
REQ-020 WAIT_SUM -> LOAD when sum_valid_i=1; sum_i latched into divisor register on that edge; sum_valid_i before WAIT_SUM ignored.
REQ-021 LOAD (1 cycle): dividend = buffer[idx] << (data_size-4), width 2*data_size-4; quotient/remainder cleared; -> DIVIDE.
REQ-022 DIVIDE: restoring division, one quotient bit per cycle, MSB first, exactly data_size cycles, then -> OUTPUT.
REQ-023 Quotient q = floor(dividend / divisor), computed at width data_size+1; prob_o = q if q < 2^data_size, else all-ones (saturate).
REQ-024 Divisor 0: DIVIDE skipped result, prob_o = all-ones for every element; timing unchanged.
REQ-025 OUTPUT (1 cycle): prob_valid_o=1, prob_o registered; prob_last_o=1 iff idx=count-1; then idx+1 -> LOAD, or -> DONE if last.
REQ-026 Per-element latency data_size+2 cycles; first prob_valid_o exactly data_size+2 cycles after WAIT_SUM->LOAD edge; total count*(data_size+2).
REQ-027 Output order equals capture order; no backpressure; prob_o holds last value between strobes.
REQ-028 DONE absorbing until reset; data_valid_i, exp_done_i, sum_valid_i ignored there.

Reset
REQ-029 reset_i=1 at a clock edge: state COLLECT, count=0, idx=0, prob_o=0, prob_valid_o=0, prob_last_o=0, busy_o=0, done_o=0, overflow_o=0; buffer contents need not be cleared.
REQ-030 Reset mid-operation (any state) aborts immediately; no further prob_valid_o until new vector completes.

Structure
REQ-031 Shared softmax package/include holds state encodings and the shift constant 4 (adder scaling), reused by adder_block and normalize_block.
REQ-032 Iterative divider is sub-module serial_divider (start, dividend, divisor, quotient, done, saturate); FSM, buffer, counters in normalize_block.

Verification (data_size=32, number_of_data=4 unless stated)
REQ-033 Four exps 0x1000_0000, exp_done, sum_i=0x0400_0000 -> four prob_o=0x4000_0000, 34 cycles apart, prob_last_o on 4th, done_o after.
REQ-034 One exp 0x0800_0000, sum_i=0x0080_0000 -> q=2^32 saturates, prob_o=0xFFFF_FFFF, prob_last_o=1.
REQ-035 Exps {0, 0x0200_0000}, sum_i=0x0020_0000 -> prob_o 0x0000_0000 then 0xFFFF_FFFF (saturated).
REQ-036 sum_i=0 with three exps -> three prob_o=0xFFFF_FFFF, normal timing.
REQ-037 Six exps into depth 4 -> overflow_o=1, exactly four outputs; exp_done with no data -> done_o next cycle, no strobes.
REQ-038 reset_i asserted in DIVIDE of element 2 -> all outputs 0 next cycle; fresh vector then produces correct results.
